drive_controller: RTL and testbench

Registered manual-drive controller for the simulated car. It replaces the loosely coupled engine and manual logic with one synchronous block containing:
- input synchronisers
- a hold-to-start power latch
- the 4-state manual-drive FSM with clutch/reverse interlock
- parametrised turn-light blinkers

It drives the 4-bit moving_state field packed into the UART frame, plus the turn lights.

---
 rtl/drive_controller.sv | 206 ++++++++++++++++++++
 tb/tb_drive_controller.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/drive_controller.sv
// Manual-drive controller: input synchronisers, hold-to-start power latch, 4-state drive FSM
// with clutch/reverse interlock and turn-light blinkers. Optional macro OBSTACLE_STOP_EN adds detector inputs.
module drive_controller #(
    parameter int PWR_HOLD_CYC   = 100_000_000,
    parameter int BLINK_HALF_CYC = 50_000_000,
    parameter int CNT_W          = 27
) (
    input  logic       sys_clk,
    input  logic       rst,
    input  logic       power_on,
    input  logic       power_off,
    input  logic       clutch,
    input  logic       throttle,
    input  logic       brake,
    input  logic       reverse,
    input  logic       turn_left,
    input  logic       turn_right,
`ifdef OBSTACLE_STOP_EN
    input  logic       front_detector,
    input  logic       back_detector,
`endif
    output logic       power,
    output logic [1:0] car_state,
    output logic [3:0] moving_state,
    output logic       turn_left_light,
    output logic       turn_right_light
);

    typedef enum logic [1:0] {
        ST_OFF          = 2'b00,
        ST_NOT_STARTING = 2'b01,
        ST_STARTING     = 2'b10,
        ST_MOVING       = 2'b11
    } state_e;

    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(PWR_HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_HALF_CYC - 1);

    // Two-flop synchronisers, one bit per asynchronous level input.
    logic [7:0] raw_in;
    logic [7:0] sync1_q;
    logic [7:0] sync2_q;

    logic power_on_s, power_off_s, clutch_s, throttle_s;
    logic brake_s, reverse_s, turn_left_s, turn_right_s;

    assign raw_in = {turn_right, turn_left, reverse, brake, throttle, clutch, power_off, power_on};

    assign power_on_s   = sync2_q[0];
    assign power_off_s  = sync2_q[1];
    assign clutch_s     = sync2_q[2];
    assign throttle_s   = sync2_q[3];
    assign brake_s      = sync2_q[4];
    assign reverse_s    = sync2_q[5];
    assign turn_left_s  = sync2_q[6];
    assign turn_right_s = sync2_q[7];

    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= raw_in;
            sync2_q <= sync1_q;
        end
    end

    state_e           state_q, state_d;
    logic             power_q, power_d;
    logic             dir_q, dir_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [CNT_W-1:0] blink_cnt_q, blink_cnt_d;
    logic             phase_q, phase_d;
    logic             act_l_q, act_l_d;
    logic             act_r_q, act_r_d;
    logic [3:0]       moving_state_q, moving_state_d;
    logic             light_l_q, light_l_d;
    logic             light_r_q, light_r_d;
    logic             stall;
    logic             obstacle;

    // Detector facing the current direction of travel; detectors arrive already synchronous.
`ifdef OBSTACLE_STOP_EN
    assign obstacle = dir_q ? back_detector : front_detector;
`else
    assign obstacle = 1'b0;
`endif

    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_OFF;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        stall   = 1'b0;
        case (state_q)
            ST_OFF: begin
                if (power_q) state_d = ST_NOT_STARTING;
            end
            ST_NOT_STARTING: begin
                if (throttle_s && !brake_s) begin
                    if (clutch_s) state_d = ST_STARTING;
                    else          stall   = 1'b1;
                end
            end
            ST_STARTING: begin
                if (brake_s)                                   state_d = ST_NOT_STARTING;
                else if (throttle_s && !clutch_s && !obstacle) state_d = ST_MOVING;
            end
            ST_MOVING: begin
                if (brake_s)                               state_d = ST_NOT_STARTING;
                else if (obstacle)                         state_d = ST_STARTING;
                else if (!throttle_s || clutch_s)          state_d = ST_STARTING;
                else if ((reverse_s != dir_q) && !clutch_s) stall  = 1'b1;
            end
            default: state_d = ST_OFF;
        endcase
        // Kill switch, stall and lost power all override the per-state transitions.
        if (power_off_s || stall || !power_q) state_d = ST_OFF;
    end

    always_comb begin
        power_d    = power_q;
        hold_cnt_d = '0;
        if (power_off_s || stall) begin
            power_d = 1'b0;
        end else if (!power_q && power_on_s) begin
            if (hold_cnt_q == HOLD_LAST) power_d    = 1'b1;
            else                         hold_cnt_d = hold_cnt_q + 1'b1;
        end
    end

    always_comb begin
        dir_d = dir_q;
        if ((state_q != ST_MOVING) || clutch_s) dir_d = reverse_s;
    end

    always_comb begin
        moving_state_d    = 4'b0000;
        moving_state_d[0] = (state_d == ST_MOVING) && !dir_d;
        moving_state_d[1] = (state_d == ST_MOVING) && dir_d;
        moving_state_d[2] = ((state_d == ST_STARTING) || (state_d == ST_MOVING)) &&
                            turn_left_s && !turn_right_s;
        moving_state_d[3] = ((state_d == ST_STARTING) || (state_d == ST_MOVING)) &&
                            turn_right_s && !turn_left_s;
    end

    // One shared blink timebase; any newly raised request restarts it so hazards blink in phase.
    always_comb begin
        act_l_d     = power_d && turn_left_s;
        act_r_d     = power_d && turn_right_s;
        blink_cnt_d = '0;
        phase_d     = 1'b0;
        if (act_l_d || act_r_d) begin
            if ((act_l_d && !act_l_q) || (act_r_d && !act_r_q)) begin
                blink_cnt_d = '0;
                phase_d     = 1'b1;
            end else if (blink_cnt_q == BLINK_LAST) begin
                blink_cnt_d = '0;
                phase_d     = !phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 1'b1;
                phase_d     = phase_q;
            end
        end
        light_l_d = act_l_d && phase_d;
        light_r_d = act_r_d && phase_d;
    end

    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            power_q        <= 1'b0;
            dir_q          <= 1'b0;
            hold_cnt_q     <= '0;
            blink_cnt_q    <= '0;
            phase_q        <= 1'b0;
            act_l_q        <= 1'b0;
            act_r_q        <= 1'b0;
            moving_state_q <= 4'b0000;
            light_l_q      <= 1'b0;
            light_r_q      <= 1'b0;
        end else begin
            power_q        <= power_d;
            dir_q          <= dir_d;
            hold_cnt_q     <= hold_cnt_d;
            blink_cnt_q    <= blink_cnt_d;
            phase_q        <= phase_d;
            act_l_q        <= act_l_d;
            act_r_q        <= act_r_d;
            moving_state_q <= moving_state_d;
            light_l_q      <= light_l_d;
            light_r_q      <= light_r_d;
        end
    end

    assign power            = power_q;
    assign car_state        = state_q;
    assign moving_state     = moving_state_q;
    assign turn_left_light  = light_l_q;
    assign turn_right_light = light_r_q;

endmodule

// File: tb/tb_drive_controller.sv
// Bench for drive_controller: reset check, directed vector table, async-reset sequence and
// randomized run-length stimulus against a cycle-level reference model.
module tb_drive_controller;
    localparam int PWR_HOLD = 8;
    localparam int HALF     = 4;

    localparam logic [7:0] PO = 8'h01, PF = 8'h02, CL = 8'h04, TH = 8'h08;
    localparam logic [7:0] BR = 8'h10, RV = 8'h20, TL = 8'h40, TR = 8'h80;

    logic       sys_clk = 1'b0;
    logic       rst;
    logic       power_on, power_off, clutch, throttle, brake, reverse, turn_left, turn_right;
    logic       front_detector = 1'b0, back_detector = 1'b0;
    logic       power;
    logic [1:0] car_state;
    logic [3:0] moving_state;
    logic       turn_left_light, turn_right_light;

    int n_checks = 0;
    int n_fail   = 0;

    logic [8:0] exp_q[$];

    always #5 sys_clk = ~sys_clk;

    drive_controller #(.PWR_HOLD_CYC(PWR_HOLD), .BLINK_HALF_CYC(HALF), .CNT_W(4)) dut (
        .sys_clk          (sys_clk),
        .rst              (rst),
        .power_on         (power_on),
        .power_off        (power_off),
        .clutch           (clutch),
        .throttle         (throttle),
        .brake            (brake),
        .reverse          (reverse),
        .turn_left        (turn_left),
        .turn_right       (turn_right),
`ifdef OBSTACLE_STOP_EN
        .front_detector   (front_detector),
        .back_detector    (back_detector),
`endif
        .power            (power),
        .car_state        (car_state),
        .moving_state     (moving_state),
        .turn_left_light  (turn_left_light),
        .turn_right_light (turn_right_light)
    );

    // Reference model: inputs delayed two cycles, hold time and blink phase as plain cycle counts.
    logic [7:0] m_s1 = '0, m_s2 = '0;
    int   m_run = 0, m_age = 0, m_st = 0;
    bit   m_pwr = 0, m_dir = 0, m_pl = 0, m_pr = 0;

    always @(posedge sys_clk or negedge rst) begin
        bit po, pf, cl, th, br, rv, tl, tr, stall, npwr, ndir, al, ar, ahead, mov, act;
        int nst;
        logic [3:0] ms;
        if (!rst) begin
            m_s1 = '0; m_s2 = '0; m_run = 0; m_age = 0; m_st = 0;
            m_pwr = 0; m_dir = 0; m_pl = 0; m_pr = 0;
            exp_q.delete();
        end else begin
            {tr, tl, rv, br, th, cl, pf, po} = m_s2;
`ifdef OBSTACLE_STOP_EN
            ahead = m_dir ? back_detector : front_detector;
`else
            ahead = 1'b0;
`endif
            stall = 0;
            nst   = m_st;
            case (m_st)
                0: if (m_pwr) nst = 1;
                1: if (th && !br) begin
                       if (cl) nst = 2; else stall = 1;
                   end
                2: if (br) nst = 1; else if (th && !cl && !ahead) nst = 3;
                default: if (br) nst = 1;
                         else if (ahead) nst = 2;
                         else if (!th || cl) nst = 2;
                         else if ((rv != m_dir) && !cl) stall = 1;
            endcase
            if (pf || stall || !m_pwr) nst = 0;

            if (po && !pf && !m_pwr) m_run++; else m_run = 0;
            if (pf || stall)  npwr = 0;
            else if (m_pwr)   npwr = 1;
            else              npwr = (m_run >= PWR_HOLD);
            if (npwr && !m_pwr) m_run = 0;

            ndir = (m_st != 3 || cl) ? rv : m_dir;
            mov  = (nst == 3);
            act  = (nst == 2) || (nst == 3);
            ms   = {act && tr && !tl, act && tl && !tr, mov && ndir, mov && !ndir};

            al = npwr && tl;
            ar = npwr && tr;
            if (!al && !ar)                           m_age = 0;
            else if ((al && !m_pl) || (ar && !m_pr))  m_age = 0;
            else                                      m_age++;
            exp_q.push_back({npwr, nst[1:0], ms,
                             al && ((m_age / HALF) % 2 == 0), ar && ((m_age / HALF) % 2 == 0)});

            m_pl = al; m_pr = ar; m_st = nst; m_pwr = npwr; m_dir = ndir;
            m_s2 = m_s1;
            m_s1 = {turn_right, turn_left, reverse, brake, throttle, clutch, power_off, power_on};
        end
    end

    function automatic logic [8:0] dut_out();
        return {power, car_state, moving_state, turn_left_light, turn_right_light};
    endfunction

    task automatic check_vec(input string name, input logic [8:0] got, input logic [8:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b (pwr,state,moving,ll,lr)", name, got, exp);
        end
    endtask

    task automatic drive(input logic [7:0] v);
        {turn_right, turn_left, reverse, brake, throttle, clutch, power_off, power_on} = v;
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge sys_clk);
            @(negedge sys_clk);
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL model: no expected entry at %0t", $time);
            end else begin
                check_vec("model", dut_out(), exp_q.pop_front());
            end
        end
    endtask

    task automatic async_reset_pulse();
        @(posedge sys_clk);
        #2 rst = 1'b0;
        #1 check_vec("async_rst", dut_out(), 9'b0);
        @(negedge sys_clk);
        rst = 1'b1;
    endtask

    typedef struct {
        int         cyc;
        logic [7:0] in;
        logic       pwr;
        logic [1:0] st;
        logic [3:0] ms;
        logic       ll;
        logic       lr;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(int cyc, logic [7:0] in, logic pwr, logic [1:0] st,
                                logic [3:0] ms, logic ll, logic lr);
        vec_t v;
        v.cyc = cyc; v.in = in; v.pwr = pwr; v.st = st; v.ms = ms; v.ll = ll; v.lr = lr;
        vecs.push_back(v);
    endfunction

    initial begin
        logic [7:0] rv_in;
        rst = 1'b0;
        drive(8'h00);
        repeat (3) @(posedge sys_clk);
        @(negedge sys_clk);
        check_vec("reset", dut_out(), 9'b0);
        rst = 1'b1;

        add(7,  PO,           0, 2'b00, 4'b0000, 0, 0);
        add(6,  8'h00,        0, 2'b00, 4'b0000, 0, 0);
        add(10, PO,           1, 2'b00, 4'b0000, 0, 0);
        add(1,  PO,           1, 2'b01, 4'b0000, 0, 0);
        add(3,  8'h00,        1, 2'b01, 4'b0000, 0, 0);
        add(3,  CL|TH,        1, 2'b10, 4'b0000, 0, 0);
        add(3,  TH,           1, 2'b11, 4'b0001, 0, 0);
        add(3,  TH|BR,        1, 2'b01, 4'b0000, 0, 0);
        add(3,  CL|TH,        1, 2'b10, 4'b0000, 0, 0);
        add(3,  TH,           1, 2'b11, 4'b0001, 0, 0);
        add(3,  TH|RV,        0, 2'b00, 4'b0000, 0, 0);
        add(3,  8'h00,        0, 2'b00, 4'b0000, 0, 0);
        add(11, PO,           1, 2'b01, 4'b0000, 0, 0);
        add(3,  CL|TH,        1, 2'b10, 4'b0000, 0, 0);
        add(3,  TH,           1, 2'b11, 4'b0001, 0, 0);
        add(3,  CL|TH|RV,     1, 2'b10, 4'b0000, 0, 0);
        add(3,  TH|RV,        1, 2'b11, 4'b0010, 0, 0);
        add(3,  TH|RV|TL,     1, 2'b11, 4'b0110, 1, 0);
        add(4,  TH|RV|TL,     1, 2'b11, 4'b0110, 0, 0);
        add(4,  TH|RV|TL,     1, 2'b11, 4'b0110, 1, 0);
        add(3,  TH|RV|TL|TR,  1, 2'b11, 4'b0010, 1, 1);
        add(4,  TH|RV|TL|TR,  1, 2'b11, 4'b0010, 0, 0);
        add(4,  TH|RV|TL|TR,  1, 2'b11, 4'b0010, 1, 1);
        add(3,  TH|RV|TL|TR|PF, 0, 2'b00, 4'b0000, 0, 0);
        add(3,  8'h00,        0, 2'b00, 4'b0000, 0, 0);

        foreach (vecs[i]) begin
            drive(vecs[i].in);
            step(vecs[i].cyc);
            check_vec($sformatf("vec%0d", i), dut_out(),
                      {vecs[i].pwr, vecs[i].st, vecs[i].ms, vecs[i].ll, vecs[i].lr});
        end

        // Reset in the middle of MOVING, then a fresh full hold is needed.
        drive(PO);     step(11);
        drive(CL|TH);  step(3);
        drive(TH);     step(3);
        check_vec("pre_rst_moving", dut_out(), {1'b1, 2'b11, 4'b0001, 1'b0, 1'b0});
        drive(PO);
        async_reset_pulse();
        step(9);
        check_vec("hold_after_rst_low", {8'b0, power}, 9'b0);
        step(1);
        check_vec("hold_after_rst_high", {8'b0, power}, 9'b1);

`ifdef OBSTACLE_STOP_EN
        drive(8'h00);  step(1);
        drive(CL|TH);  step(3);
        drive(TH);     step(3);
        front_detector = 1'b1;
        step(1);
        check_vec("obstacle_stop", dut_out(), {1'b1, 2'b10, 4'b0000, 1'b0, 1'b0});
        step(3);
        check_vec("obstacle_hold", dut_out(), {1'b1, 2'b10, 4'b0000, 1'b0, 1'b0});
        front_detector = 1'b0;
        step(1);
        check_vec("obstacle_clear", dut_out(), {1'b1, 2'b11, 4'b0001, 1'b0, 1'b0});
`endif

        for (int k = 0; k < 300; k++) begin
            rv_in = '0;
            if ($urandom_range(0, 9) < 7)  rv_in |= PO;
            if ($urandom_range(0, 19) == 0) rv_in |= PF;
            if ($urandom_range(0, 1) == 1) rv_in |= CL;
            if ($urandom_range(0, 3) != 0) rv_in |= TH;
            if ($urandom_range(0, 3) == 0) rv_in |= BR;
            if ($urandom_range(0, 4) == 0) rv_in |= RV;
            if ($urandom_range(0, 2) == 0) rv_in |= TL;
            if ($urandom_range(0, 2) == 0) rv_in |= TR;
            drive(rv_in);
`ifdef OBSTACLE_STOP_EN
            front_detector = ($urandom_range(0, 7) == 0);
            back_detector  = ($urandom_range(0, 7) == 0);
`endif
            if ($urandom_range(0, 49) == 0) async_reset_pulse();
            step($urandom_range(1, 12));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
